// File: rtl/led_tx_pkg.sv
// Shared definitions for the LED frame transmitter: FSM encoding, default
// bit/latch timing constants and small elaboration-time helpers.
package led_tx_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    LATCH = 3'd4
  } state_t;

  // Default timing in clk cycles
  localparam int unsigned TBIT_DEF = 63;
  localparam int unsigned T0H_DEF  = 20;
  localparam int unsigned T1H_DEF  = 40;
  localparam int unsigned TRST_DEF = 15000;

  // Pixel format: 24-bit GRB, sent MSB first
  localparam int unsigned PIX_W        = 24;
  localparam int unsigned BITS_PER_PIX = 24;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a range of n values, at least one bit
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Per-symbol waveform generator. A go pulse starts either a data bit
// (high for T1H/T0H cycles, low for the rest of TBIT) or the end-of-frame
// latch (low for TRST cycles). done_c flags the last cycle of the symbol so
// the caller can issue the next go in the same cycle without a gap.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   go          start a symbol (takes priority over done_c)
//   bit_val     data bit value for a data symbol
//   latch       1: latch symbol, 0: data symbol
//   dout        registered serial line
//   done_c      combinational, last cycle of the running symbol
module led_bit_timer
  import led_tx_pkg::*;
#(
  parameter int unsigned TBIT = TBIT_DEF,
  parameter int unsigned T0H  = T0H_DEF,
  parameter int unsigned T1H  = T1H_DEF,
  parameter int unsigned TRST = TRST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic bit_val,
  input  logic latch,
  output logic dout,
  output logic done_c
);

  localparam int unsigned CMAX = max_u(TBIT, TRST);
  localparam int unsigned CW   = width_of(CMAX);

  logic          active;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [CW-1:0] hi;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + CW'(1);
  assign done_c  = active && (cnt == last);

  // Symbol counter and line driver; dout reflects the cycle that cnt will hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      last   <= '0;
      hi     <= '0;
      dout   <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      cnt    <= '0;
      last   <= latch ? CW'(TRST - 1) : CW'(TBIT - 1);
      hi     <= latch ? '0 : (bit_val ? CW'(T1H) : CW'(T0H));
      dout   <= !latch;
    end else if (done_c) begin
      active <= 1'b0;
      cnt    <= '0;
      dout   <= 1'b0;
    end else if (active) begin
      cnt    <= cnt_inc;
      dout   <= (cnt_inc < hi);
    end
  end

endmodule

// File: rtl/led_frame_tx.sv
// Serial LED frame transmitter. On start it reads NUM_LEDS GRB pixels from an
// external one-cycle-latency memory and shifts them out MSB first as
// pulse-width coded bits, then holds the line low for the latch period and
// pulses finish. The next pixel is prefetched during bit 23 of the current
// one so consecutive pixels are sent without a gap.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       frame request, only looked at while idle
//   busy        frame in progress
//   pix_rd      one-cycle pixel read strobe, pix_addr holds the index
//   pix_data    pixel returned one cycle after pix_rd
//   dout        serial LED data line
//   finish      one-cycle pulse once frame and latch are complete
module led_frame_tx
  import led_tx_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 64,
  parameter int unsigned AW       = 6,
  parameter int unsigned TBIT     = TBIT_DEF,
  parameter int unsigned T0H      = T0H_DEF,
  parameter int unsigned T1H      = T1H_DEF,
  parameter int unsigned TRST     = TRST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             pix_rd,
  output logic [AW-1:0]    pix_addr,
  input  logic [PIX_W-1:0] pix_data,
  output logic             dout,
  output logic             finish
);

  localparam int unsigned PW = width_of(NUM_LEDS);
  localparam int unsigned BW = width_of(BITS_PER_PIX);

  state_t           state;
  state_t           state_n;
  logic             go_c;
  logic             bit_c;
  logic             latch_c;
  logic             done_c;
  logic             busy_n;
  logic             pix_rd_n;
  logic             finish_n;
  logic [AW-1:0]    pix_addr_n;
  logic [PIX_W-1:0] sh;
  logic [PIX_W-1:0] hold;
  logic [BW-1:0]    bit_cnt;
  logic [PW-1:0]    pix_cnt;
  logic             rd_d;
  logic             last_bit_c;
  logic             pre_bit_c;
  logic             last_pix_c;

  assign last_bit_c = (bit_cnt == BW'(BITS_PER_PIX - 1));
  assign pre_bit_c  = (bit_cnt == BW'(BITS_PER_PIX - 2));
  assign last_pix_c = (pix_cnt == PW'(NUM_LEDS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, symbol requests and next values of the registered outputs
  always_comb begin
    state_n    = state;
    go_c       = 1'b0;
    bit_c      = 1'b0;
    latch_c    = 1'b0;
    pix_rd_n   = 1'b0;
    pix_addr_n = pix_addr;
    finish_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = FETCH;
          pix_rd_n   = 1'b1;
          pix_addr_n = '0;
        end
      end
      FETCH: begin
        state_n = WAIT;
      end
      WAIT: begin
        state_n = SEND;
        go_c    = 1'b1;
        bit_c   = pix_data[PIX_W-1];
      end
      SEND: begin
        if (done_c) begin
          go_c = 1'b1;
          if (!last_bit_c) begin
            bit_c = sh[PIX_W-2];
            // Bit 23 is about to start: fetch the next pixel
            if (pre_bit_c && !last_pix_c) begin
              pix_rd_n   = 1'b1;
              pix_addr_n = AW'(pix_cnt) + AW'(1);
            end
          end else if (!last_pix_c) begin
            bit_c = hold[PIX_W-1];
          end else begin
            latch_c = 1'b1;
            state_n = LATCH;
          end
        end
      end
      LATCH: begin
        if (done_c) begin
          state_n  = IDLE;
          finish_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      pix_rd   <= 1'b0;
      pix_addr <= '0;
      finish   <= 1'b0;
    end else begin
      busy     <= busy_n;
      pix_rd   <= pix_rd_n;
      pix_addr <= pix_addr_n;
      finish   <= finish_n;
    end
  end

  // Pixel shift/hold registers and bit/pixel counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      hold    <= '0;
      bit_cnt <= '0;
      pix_cnt <= '0;
      rd_d    <= 1'b0;
    end else begin
      // Prefetched data arrives the cycle after its strobe
      rd_d <= pix_rd && (state == SEND);
      if (rd_d) begin
        hold <= pix_data;
      end
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          pix_cnt <= '0;
        end
        WAIT: begin
          sh      <= pix_data;
          bit_cnt <= '0;
        end
        SEND: begin
          if (done_c) begin
            if (!last_bit_c) begin
              sh      <= {sh[PIX_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + BW'(1);
            end else if (!last_pix_c) begin
              sh      <= hold;
              bit_cnt <= '0;
              pix_cnt <= pix_cnt + PW'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Symbol waveform generator
  led_bit_timer #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H),
    .TRST (TRST)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (go_c),
    .bit_val (bit_c),
    .latch   (latch_c),
    .dout    (dout),
    .done_c  (done_c)
  );

endmodule

// File: tb/tb_led_frame_tx.sv
// Self-checking bench for led_frame_tx with a small pixel memory model and a
// scoreboard of expected bit values against the decoded serial line.
module tb_led_frame_tx;

  localparam int NL    = 2;
  localparam int AW    = 6;
  localparam int TBIT  = 10;
  localparam int T0H   = 3;
  localparam int T1H   = 7;
  localparam int TRST  = 50;
  localparam int FRAME = 3 + NL * 24 * TBIT + TRST;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data;
  logic          dout;
  logic          finish;

  led_frame_tx #(
    .NUM_LEDS (NL),
    .AW       (AW),
    .TBIT     (TBIT),
    .T0H      (T0H),
    .T1H      (T1H),
    .TRST     (TRST)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .pix_rd   (pix_rd),
    .pix_addr (pix_addr),
    .pix_data (pix_data),
    .dout     (dout),
    .finish   (finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory: data valid the cycle after the strobe, noise otherwise
  logic [23:0] mem [64];
  always @(posedge clk) pix_data <= pix_rd ? mem[pix_addr] : 24'($urandom);

  // Line monitor
  int   rise_q[$];
  int   hi_q[$];
  int   rd_t_q[$];
  int   rd_a_q[$];
  int   fin_q[$];
  bit   exp_q[$];
  logic dout_q = 1'b0;
  int   hi_cnt = 0;

  always @(negedge clk) begin
    if (dout === 1'b1 && dout_q !== 1'b1) begin
      rise_q.push_back(cyc);
      hi_cnt = 1;
    end else if (dout === 1'b1) begin
      hi_cnt++;
    end
    if (dout !== 1'b1 && dout_q === 1'b1) hi_q.push_back(hi_cnt);
    dout_q = dout;
    if (pix_rd === 1'b1) begin
      rd_t_q.push_back(cyc);
      rd_a_q.push_back(int'(pix_addr));
    end
    if (finish === 1'b1) fin_q.push_back(cyc);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_expected();
    for (int k = 0; k < NL; k++)
      for (int b = 23; b >= 0; b--)
        exp_q.push_back(mem[k][b]);
  endtask

  task automatic start_frame(output int s);
    s = cyc;
    start = 1'b1;
    push_expected();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_finish();
    int n = 0;
    while (fin_q.size() == 0 && n < FRAME + 100) begin
      tick();
      n++;
    end
    n_total++;
    if (fin_q.size() == 0) $display("FAIL finish_timeout: no finish after %0d cycles", n);
    else n_pass++;
  endtask

  task automatic check_frame(input int s);
    int r;
    int h;
    int e_hi;
    int t;
    int a;
    int e_t;
    bit e;
    for (int b = 0; b < NL * 24; b++) begin
      n_total++;
      if (rise_q.size() == 0) begin
        $display("FAIL rise_time[%0d]: got none, expected cycle %0d", b, s + 3 + b * TBIT);
      end else begin
        r = rise_q.pop_front();
        if (r !== s + 3 + b * TBIT)
          $display("FAIL rise_time[%0d]: got %0d, expected %0d", b, r - s, 3 + b * TBIT);
        else n_pass++;
      end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
      e_hi = e ? T1H : T0H;
      n_total++;
      if (hi_q.size() == 0) begin
        $display("FAIL high_len[%0d]: got none, expected %0d", b, e_hi);
      end else begin
        h = hi_q.pop_front();
        if (h !== e_hi) $display("FAIL high_len[%0d]: got %0d, expected %0d", b, h, e_hi);
        else n_pass++;
      end
    end
    for (int k = 0; k < NL; k++) begin
      e_t = (k == 0) ? s + 1 : s + 3 + ((k - 1) * 24 + 23) * TBIT;
      n_total += 2;
      if (rd_t_q.size() == 0) begin
        $display("FAIL pix_rd[%0d]: got none, expected cycle %0d addr %0d", k, e_t - s, k);
      end else begin
        t = rd_t_q.pop_front();
        a = rd_a_q.pop_front();
        if (t !== e_t) $display("FAIL pix_rd_time[%0d]: got %0d, expected %0d", k, t - s, e_t - s);
        else n_pass++;
        if (a !== k) $display("FAIL pix_rd_addr[%0d]: got %0d, expected %0d", k, a, k);
        else n_pass++;
      end
    end
    n_total++;
    if (fin_q.size() == 0) begin
      $display("FAIL finish_time: got none, expected %0d", FRAME);
    end else begin
      t = fin_q.pop_front();
      if (t !== s + FRAME) $display("FAIL finish_time: got %0d, expected %0d", t - s, FRAME);
      else n_pass++;
    end
  endtask

  task automatic check_quiet(input string tag);
    n_total++;
    if (rise_q.size() != 0) $display("FAIL %s_extra_rises: got %0d, expected 0", tag, rise_q.size());
    else n_pass++;
    n_total++;
    if (rd_t_q.size() != 0) $display("FAIL %s_extra_pix_rd: got %0d, expected 0", tag, rd_t_q.size());
    else n_pass++;
    n_total++;
    if (fin_q.size() != 0) $display("FAIL %s_extra_finish: got %0d, expected 0", tag, fin_q.size());
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_busy_idle: got %b, expected 0", tag, busy);
    else n_pass++;
  endtask

  task automatic clear_scoreboard();
    rise_q.delete();
    hi_q.delete();
    rd_t_q.delete();
    rd_a_q.delete();
    fin_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    n_total += 5;
    if (dout !== 1'b0) $display("FAIL reset_dout: got %b, expected 0", dout); else n_pass++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
    if (pix_rd !== 1'b0) $display("FAIL reset_pix_rd: got %b, expected 0", pix_rd); else n_pass++;
    if (pix_addr !== '0) $display("FAIL reset_pix_addr: got %0d, expected 0", pix_addr); else n_pass++;
    if (finish !== 1'b0) $display("FAIL reset_finish: got %b, expected 0", finish); else n_pass++;
    rst_n = 1'b1;
    repeat (3) tick();
    check_quiet("post_reset");
    clear_scoreboard();
  endtask

  task automatic test_all_ones();
    int s;
    mem[0] = 24'hFFFFFF;
    mem[1] = 24'h000000;
    start_frame(s);
    n_total++;
    if (busy !== 1'b1) $display("FAIL ones_busy: got %b, expected 1", busy); else n_pass++;
    wait_finish();
    check_frame(s);
    repeat (5) tick();
    check_quiet("ones");
  endtask

  task automatic test_pattern();
    int s;
    mem[0] = 24'hA50000;
    mem[1] = 24'h5A3C96;
    start_frame(s);
    wait_finish();
    check_frame(s);
    repeat (5) tick();
    check_quiet("pattern");
  endtask

  task automatic test_start_ignored();
    int s;
    mem[0] = 24'($urandom);
    mem[1] = 24'($urandom);
    start_frame(s);
    while (cyc < s + 10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < s + 200) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_finish();
    check_frame(s);
    repeat (60) tick();
    check_quiet("ignored");
  endtask

  task automatic test_reset_midframe();
    int s;
    mem[0] = 24'($urandom);
    mem[1] = 24'($urandom);
    start_frame(s);
    while (cyc < s + 100) tick();
    rst_n = 1'b0;
    #1;
    n_total += 3;
    if (dout !== 1'b0) $display("FAIL abort_dout: got %b, expected 0", dout); else n_pass++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b, expected 0", busy); else n_pass++;
    if (pix_rd !== 1'b0) $display("FAIL abort_pix_rd: got %b, expected 0", pix_rd); else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (FRAME) tick();
    n_total++;
    if (fin_q.size() != 0) $display("FAIL abort_finish: got %0d pulses, expected 0", fin_q.size());
    else n_pass++;
    clear_scoreboard();
    mem[0] = 24'h00FF0F;
    mem[1] = 24'hC30081;
    start_frame(s);
    wait_finish();
    check_frame(s);
    repeat (5) tick();
    check_quiet("restart");
  endtask

  task automatic test_back_to_back();
    int s1;
    int f1;
    mem[0] = 24'($urandom);
    mem[1] = 24'($urandom);
    s1 = cyc;
    start = 1'b1;
    push_expected();
    wait_finish();
    f1 = (fin_q.size() != 0) ? fin_q[0] : s1 + FRAME;
    push_expected();
    repeat (3) tick();
    start = 1'b0;
    check_frame(s1);
    wait_finish();
    check_frame(f1);
    repeat (60) tick();
    check_quiet("b2b");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 24'h0;
    test_reset();
    test_all_ones();
    test_pattern();
    test_start_ignored();
    test_reset_midframe();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/led_frame_tx.md
LED_FRAME_TX -- requirements
Module: led_frame_tx

Interface
REQ-001 Parameters SHALL be:
  NUM_LEDS, 64, pixels per frame (1..2^AW)
  AW, 6, pixel address width
  TBIT, 63, clk cycles per data bit
  T0H, 20, high cycles for a 0 bit (T0H < T1H < TBIT)
  T1H, 40, high cycles for a 1 bit
  TRST, 15000, low cycles of the end-of-frame latch
REQ-002 Clock and reset SHALL be: one clock, asynchronous active-low reset.
REQ-003 Ports SHALL be:
  clk       in   1   system clock, rising edge
  rst_n     in   1   asynchronous active-low reset
  start     in   1   frame request, sampled only when busy=0
  busy      out  1   frame in progress
  pix_rd    out  1   pixel read strobe, one cycle
  pix_addr  out  AW  pixel index for pix_rd
  pix_data  in   24  GRB pixel, valid exactly 1 cycle after pix_rd
  dout      out  1   serial LED data line
  finish    out  1   one-cycle pulse, frame plus latch complete

Function
REQ-004 All outputs SHALL be registered.
REQ-005 States SHALL be IDLE, FETCH, WAIT, SEND, LATCH.
REQ-006 IDLE: dout=0, busy=0, pix_rd=0; start=1 in cycle S -> FETCH at S+1.
REQ-007 FETCH (S+1): busy=1, pix_rd=1, pix_addr=0; -> WAIT.
REQ-008 WAIT (S+2): pix_data captured into shift register; -> SEND; first bit drives dout=1 from S+3.
REQ-009 SEND: 24 bits per pixel, MSB (G7) first; each bit TBIT cycles; dout=1 for T1H (bit=1) or T0H (bit=0) cycles, then 0 for the remainder.
REQ-010 Prefetch: in the first cycle of bit 23 of pixel k (k < NUM_LEDS-1), pix_rd=1 with pix_addr=k+1; data captured the next cycle into a holding register and loaded at the bit-23 boundary, giving no gap between pixels.
REQ-011 No pix_rd SHALL be issued for pixel index >= NUM_LEDS; pix_data SHALL be ignored except in the capture cycle.
REQ-012 After the last bit of the last pixel -> LATCH: dout=0 for exactly TRST cycles.
REQ-013 In the cycle after LATCH ends: state IDLE, finish=1, busy=0; start=1 in that same cycle SHALL be accepted.
REQ-014 start while busy=1 SHALL be ignored; it SHALL not be queued.
REQ-015 dout rising edge of the first bit SHALL occur at S+3; finish SHALL occur at S+3+NUM_LEDS*24*TBIT+TRST.
REQ-016 Bit counter (0..23), pixel counter (0..NUM_LEDS-1) and cycle counter (0..max(TBIT,TRST)-1) SHALL size to ceil(log2) of their ranges and SHALL never wrap past their terminal values.

Reset
REQ-017 rst_n=0 SHALL immediately force state=IDLE, dout=0, busy=0, pix_rd=0, pix_addr=0, finish=0, and clear all counters and data registers.
REQ-018 Reset mid-frame SHALL abort the frame with no finish pulse; the next frame after release SHALL restart at pixel 0.

Structure
REQ-019 Package led_tx_pkg SHALL hold the state encoding and the default timing constants (TBIT, T0H, T1H, TRST).
REQ-020 Sub-module led_bit_timer SHALL generate the per-bit high/low waveform and the bit-done strobe from a bit value and a go pulse.

Verification
Bench parameters: NUM_LEDS=2, TBIT=10, T0H=3, T1H=7, TRST=50.
REQ-021 Pixel 0=0xFFFFFF, pixel 1=0x000000, start at S -> dout high 7 of 10 cycles for bits 0-23 and high 3 of 10 for bits 24-47; first rise at S+3; finish at S+533.
REQ-022 Pixel 0=0xA50000 -> dout pattern 1,0,1,0,0,1,0,1 for the first 8 bits; pix_rd with addr=1 exactly once, at S+3+230.
REQ-023 start pulses at S+10 and S+200 -> no effect; exactly one finish pulse.
REQ-024 rst_n low at S+100 for 2 cycles -> dout=0 and busy=0 immediately; no finish; new start re-reads addr 0.
REQ-025 start held high continuously -> back-to-back frames; each new FETCH follows a finish cycle directly; the first rise of frame 2 is 3 cycles after frame 1's finish.
